// File: rtl/timer_ctrl_pkg.sv
// Shared types for the command-driven timer controller.
// Holds the command opcode and FSM state encodings plus a legality helper.
// No logic; imported by timer_ctrl and timer_ctrl_cnt.
package timer_ctrl_pkg;

    localparam int OP_W = 2;
    localparam int ST_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_START  = 2'd0,
        OP_PAUSE  = 2'd1,
        OP_RESUME = 2'd2,
        OP_STOP   = 2'd3
    } op_e;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // START and STOP are legal anywhere (STOP in IDLE is a silent no-op);
    // PAUSE only makes sense while running, RESUME only while paused.
    function automatic logic op_legal(input op_e op, input state_e st);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_START:  ok = 1'b1;
            OP_PAUSE:  ok = (st == ST_RUN);
            OP_RESUME: ok = (st == ST_PAUSE);
            OP_STOP:   ok = 1'b1;
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/timer_ctrl_cnt.sv
// Purpose: W-bit up-counter with synchronous reset, clear and enable.
// Latency: clr_i/en_i take effect on the next clk_i edge; q_o is a flop.
// Backpressure: none; the controller decides every cycle whether to step.
module timer_ctrl_cnt
    import timer_ctrl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] q_o
);

    // Clear wins over increment. Wrap at the terminal value is commanded by
    // the controller through clr_i, so the natural 2^W rollover is never the
    // mechanism that returns the count to zero.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= q_o + W'(1);
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Purpose: command FSM sequencing a prescaled up-counter into a periodic/one-shot timer.
// Latency: a command accepted at cycle N is visible on all registered outputs at N+1.
// Backpressure: cmd_ready_o drops only while rst_i is high; commands are never queued.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int DW  = 8,
    parameter int PSW = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           cmd_valid_i,
    output logic           cmd_ready_o,
    input  logic [1:0]     cmd_op_i,
    input  logic [DW-1:0]  cmd_period_i,
    input  logic [PSW-1:0] cmd_presc_i,
    input  logic           cmd_oneshot_i,
    output logic [DW-1:0]  count_o,
    output logic           tick_o,
    output logic           busy_o,
    output logic           done_o,
    output logic           err_o
);

    state_e         state_q, state_d;
    op_e            cmd_op;
    logic           cmd_acc;

    logic [DW-1:0]  period_q;
    logic [PSW-1:0] presc_q;
    logic           oneshot_q;
    logic           load_cfg;

    logic [DW-1:0]  cnt_q;
    logic [PSW-1:0] psc_q;
    logic           cnt_clr, cnt_en;
    logic           psc_clr, psc_en;

    logic           tick_q, tick_d;
    logic           done_q, done_d;
    logic           err_q,  err_d;

    assign cmd_ready_o = ~rst_i;
    assign cmd_acc     = cmd_valid_i & cmd_ready_o;
    assign cmd_op      = op_e'(cmd_op_i);

    // Main count: steps once per prescaler rollover, cleared at terminal count.
    timer_ctrl_cnt #(.W(DW)) u_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .q_o   (cnt_q)
    );

    // Prescaler: counts 0..PS, one counter step per PS+1 RUN cycles.
    timer_ctrl_cnt #(.W(PSW)) u_psc (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (psc_clr),
        .en_i  (psc_en),
        .q_o   (psc_q)
    );

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Period, prescale and mode are captured only when START is accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_q  <= '0;
            presc_q   <= '0;
            oneshot_q <= 1'b0;
        end else if (load_cfg) begin
            period_q  <= cmd_period_i;
            presc_q   <= cmd_presc_i;
            oneshot_q <= cmd_oneshot_i;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            tick_q <= tick_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    // Next state and counter controls. An accepted command always takes
    // priority over the RUN-state step, so a terminal step coinciding with a
    // command is dropped along with its tick; a PAUSE in that cycle leaves
    // count == P and prescaler == PS, making the first RUN cycle after RESUME
    // the terminal step.
    always_comb begin
        state_d  = state_q;
        load_cfg = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        psc_clr  = 1'b0;
        psc_en   = 1'b0;
        tick_d   = 1'b0;
        done_d   = done_q;
        err_d    = 1'b0;

        if (cmd_acc) begin
            if (!op_legal(cmd_op, state_q)) begin
                err_d = 1'b1;
            end else begin
                case (cmd_op)
                    OP_START: begin
                        load_cfg = 1'b1;
                        cnt_clr  = 1'b1;
                        psc_clr  = 1'b1;
                        done_d   = 1'b0;
                        state_d  = ST_RUN;
                    end
                    OP_PAUSE: begin
                        state_d = ST_PAUSE;
                    end
                    OP_RESUME: begin
                        state_d = ST_RUN;
                    end
                    OP_STOP: begin
                        if (state_q != ST_IDLE) begin
                            cnt_clr = 1'b1;
                            psc_clr = 1'b1;
                            done_d  = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                        err_d = 1'b1;
                    end
                endcase
            end
        end else if (state_q == ST_RUN) begin
            if (psc_q == presc_q) begin
                psc_clr = 1'b1;
                if (cnt_q == period_q) begin
                    cnt_clr = 1'b1;
                    tick_d  = 1'b1;
                    if (oneshot_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end else begin
                psc_en = 1'b1;
            end
        end
    end

    assign count_o = cnt_q;
    assign tick_o  = tick_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign busy_o  = (state_q == ST_RUN) || (state_q == ST_PAUSE);

endmodule

// File: tb/tb_timer_ctrl.sv
// Purpose: randomized plus directed stimulus for timer_ctrl against a position-in-period model.
// Latency: expected outputs for each cycle are queued by the driver and checked on the falling edge.
// Backpressure: cmd_ready_o is predicted from rst_i alone and checked every cycle.
module tb_timer_ctrl;

    localparam int DW  = 8;
    localparam int PSW = 4;

    logic           clk_i;
    logic           rst_i;
    logic           cmd_valid_i;
    logic           cmd_ready_o;
    logic [1:0]     cmd_op_i;
    logic [DW-1:0]  cmd_period_i;
    logic [PSW-1:0] cmd_presc_i;
    logic           cmd_oneshot_i;
    logic [DW-1:0]  count_o;
    logic           tick_o;
    logic           busy_o;
    logic           done_o;
    logic           err_o;

    timer_ctrl #(.DW(DW), .PSW(PSW)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_op_i      (cmd_op_i),
        .cmd_period_i  (cmd_period_i),
        .cmd_presc_i   (cmd_presc_i),
        .cmd_oneshot_i (cmd_oneshot_i),
        .count_o       (count_o),
        .tick_o        (tick_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        int cyc;
        int cnt;
        int tick;
        int busy;
        int done;
        int err;
        int rdy;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_no = 0;

    // Reference model: the timer is described by its position inside the
    // current period, pos in 0 .. (P+1)*(PS+1)-1; count is pos / (PS+1).
    typedef enum int { M_IDLE, M_RUN, M_PAUSE, M_DONE } mst_t;
    mst_t m_st   = M_IDLE;
    int   m_p    = 0;
    int   m_ps   = 0;
    int   m_os   = 0;
    int   m_pos  = 0;
    int   m_tick = 0;
    int   m_done = 0;
    int   m_err  = 0;

    task automatic chk(input string nm, input int cyc, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input int op,
                              input int p, input int ps, input bit os);
        int total;
        if (r) begin
            m_st = M_IDLE; m_pos = 0; m_tick = 0; m_done = 0; m_err = 0;
            return;
        end
        m_tick = 0;
        m_err  = 0;
        if (v) begin
            case (op)
                0: begin
                    m_p = p; m_ps = ps; m_os = os;
                    m_pos = 0; m_done = 0; m_st = M_RUN;
                end
                1: if (m_st == M_RUN) m_st = M_PAUSE; else m_err = 1;
                2: if (m_st == M_PAUSE) m_st = M_RUN; else m_err = 1;
                default: if (m_st != M_IDLE) begin
                    m_st = M_IDLE; m_pos = 0; m_done = 0;
                end
            endcase
        end else if (m_st == M_RUN) begin
            total = (m_p + 1) * (m_ps + 1);
            if (m_pos == total - 1) begin
                m_pos  = 0;
                m_tick = 1;
                if (m_os != 0) begin
                    m_st   = M_DONE;
                    m_done = 1;
                end
            end else begin
                m_pos++;
            end
        end
    endtask

    // One cycle: drive inputs after the edge, queue what the DUT must show
    // this cycle, then advance the model across the coming edge.
    task automatic cyc(input bit r, input bit v, input int op,
                       input int p, input int ps, input bit os);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_i         = r;
        cmd_valid_i   = v;
        cmd_op_i      = op[1:0];
        cmd_period_i  = p[DW-1:0];
        cmd_presc_i   = ps[PSW-1:0];
        cmd_oneshot_i = os;
        e.cyc  = cyc_no;
        e.cnt  = m_pos / (m_ps + 1);
        e.tick = m_tick;
        e.busy = (m_st == M_RUN || m_st == M_PAUSE) ? 1 : 0;
        e.done = m_done;
        e.err  = m_err;
        e.rdy  = r ? 0 : 1;
        sb.push_back(e);
        cyc_no++;
        model_step(r, v, op, p, ps, os);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic cmd(input int op, input int p, input int ps, input bit os);
        cyc(1'b0, 1'b1, op, p, ps, os);
    endtask

    // Monitor: every cycle the DUT presents a full output set; compare it
    // against the oldest queued expectation.
    always @(negedge clk_i) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("count_o",     mon_e.cyc, int'(count_o),     mon_e.cnt);
            chk("tick_o",      mon_e.cyc, int'(tick_o),      mon_e.tick);
            chk("busy_o",      mon_e.cyc, int'(busy_o),      mon_e.busy);
            chk("done_o",      mon_e.cyc, int'(done_o),      mon_e.done);
            chk("err_o",       mon_e.cyc, int'(err_o),       mon_e.err);
            chk("cmd_ready_o", mon_e.cyc, int'(cmd_ready_o), mon_e.rdy);
        end
    end

    initial begin
        rst_i         = 1'b1;
        cmd_valid_i   = 1'b0;
        cmd_op_i      = 2'd0;
        cmd_period_i  = '0;
        cmd_presc_i   = '0;
        cmd_oneshot_i = 1'b0;
        repeat (2) @(posedge clk_i);

        // Reset state, then periodic P=3 PS=0.
        idle(2);
        cmd(0, 3, 0, 1'b0);
        idle(14);

        // One-shot P=2 PS=1.
        cmd(0, 2, 1, 1'b1);
        idle(10);

        // Pause at count 2, hold, resume.
        cmd(0, 5, 0, 1'b0);
        idle(2);
        cmd(1, 0, 0, 1'b0);
        idle(10);
        cmd(2, 0, 0, 1'b0);
        idle(8);

        // Illegal ops and STOP in IDLE.
        cmd(3, 0, 0, 1'b0);
        cmd(1, 0, 0, 1'b0);
        idle(2);
        cmd(3, 0, 0, 1'b0);
        idle(1);
        cmd(0, 4, 0, 1'b0);
        idle(1);
        cmd(2, 0, 0, 1'b0);
        idle(3);
        cmd(3, 0, 0, 1'b0);
        idle(2);

        // STOP on the terminal-step cycle, then START from DONE.
        cmd(0, 1, 0, 1'b0);
        idle(1);
        cmd(3, 0, 0, 1'b0);
        idle(3);
        cmd(0, 0, 0, 1'b1);
        idle(3);
        cmd(0, 2, 0, 1'b0);
        idle(5);

        // PAUSE on the terminal-step cycle resumes straight into the tick.
        cmd(0, 1, 0, 1'b0);
        idle(1);
        cmd(1, 0, 0, 1'b0);
        idle(3);
        cmd(2, 0, 0, 1'b0);
        idle(4);

        // Reset mid-RUN with a command present, then full-range wrap.
        cmd(0, 255, 0, 1'b0);
        idle(5);
        cyc(1'b1, 1'b1, 0, 7, 0, 1'b0);
        cyc(1'b1, 1'b0, 0, 0, 0, 1'b0);
        idle(2);
        cmd(0, 255, 0, 1'b0);
        idle(262);
        cmd(3, 0, 0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, v, os;
            int op, p, ps;
            r  = ($urandom_range(0, 199) == 0);
            v  = ($urandom_range(0, 7) == 0);
            op = $urandom_range(0, 3);
            p  = ($urandom_range(0, 15) == 0) ? 255 : $urandom_range(0, 7);
            ps = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            os = $urandom_range(0, 1);
            if (op == 0 && $urandom_range(0, 1) == 0) op = $urandom_range(1, 3);
            cyc(r, v, op, p, ps, os);
        end
        idle(1);

        // Drain: the monitor must consume every queued expectation.
        repeat (3) @(negedge clk_i);
        #1;
        chk("scoreboard_drain", cyc_no, sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
